// File: rtl/serial_adder_if.sv
// Start/done handshake and operand/result bus for the bit-serial adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, input busy, done, sum, cout);
  modport slave  (input start, a, b, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: a full adder built from two half adders adds two
// WIDTH-bit operands LSB-first, one bit per clock, under start/done.

module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// RUN   | one operand bit pair added per edge, LSB first
// DONE  | one-cycle done pulse; result already on sum/cout
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_psum;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_carry;
  logic [CW-1:0]    r_count;

  logic             w_s0;
  logic             w_c0;
  logic             w_s;
  logic             w_c1;
  logic             w_carry_next;
  logic [WIDTH-1:0] w_psum_next;
  logic             w_last;

  half_adder u_ha0 (.i_a(r_op_a[0]), .i_b(r_op_b[0]), .o_s(w_s0), .o_c(w_c0));
  half_adder u_ha1 (.i_a(w_s0),      .i_b(r_carry),   .o_s(w_s),  .o_c(w_c1));

  assign w_carry_next = w_c0 | w_c1;
  assign w_last       = (r_count == CW'(WIDTH - 1));

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_psum_w1
      assign w_psum_next = w_s;
    end else begin : g_psum_wn
      assign w_psum_next = {w_s, r_psum[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next_state = S_RUN;
      S_RUN:   if (w_last)    w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: operand capture, bit-serial add, result load on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_psum  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_carry <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op_a  <= bus.a;
            r_op_b  <= bus.b;
            r_carry <= 1'b0;
            r_count <= '0;
          end
        end
        S_RUN: begin
          r_op_a  <= r_op_a >> 1;
          r_op_b  <= r_op_b >> 1;
          r_carry <= w_carry_next;
          r_psum  <= w_psum_next;
          r_count <= r_count + CW'(1);
          if (w_last) begin
            r_sum  <= w_psum_next;
            r_cout <= w_carry_next;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs are decoded from the registered state.
  always_comb begin
    bus.busy = (r_state != S_IDLE);
    bus.done = (r_state == S_DONE);
    bus.sum  = r_sum;
    bus.cout = r_cout;
  end
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH=8 and WIDTH=1 against an arithmetic model.
module tb_serial_adder;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [7:0] last_sum8;
  logic       last_cout8;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // smode: 0 start low while busy, 1 random start while busy,
  //        2 start held high, 3 start pulsed at RUN cycle 4 and in DONE.
  task automatic add8(input logic [7:0] av, input logic [7:0] bv, input int smode, input bit noisy);
    logic [8:0] full;
    full = {1'b0, av} + {1'b0, bv};
    bus8.start = 1'b1;
    bus8.a     = av;
    bus8.b     = bv;
    step();
    chk("acc_busy", 64'(bus8.busy), 64'd1);
    chk("acc_done", 64'(bus8.done), 64'd0);
    for (int k = 1; k <= 9; k++) begin
      case (smode)
        0:       bus8.start = 1'b0;
        1:       bus8.start = 1'($urandom_range(0, 1));
        2:       bus8.start = 1'b1;
        default: bus8.start = (k == 4) || (k == 9);
      endcase
      if (noisy) begin
        bus8.a = 8'($urandom);
        bus8.b = 8'($urandom);
      end
      step();
      if (k <= 8) begin
        chk("run_busy", 64'(bus8.busy), 64'd1);
        chk("run_done", 64'(bus8.done), 64'(k == 8));
        if (k < 8) begin
          chk("hold_sum",  64'(bus8.sum),  64'(last_sum8));
          chk("hold_cout", 64'(bus8.cout), 64'(last_cout8));
        end else begin
          chk("res_sum",  64'(bus8.sum),  64'(full[7:0]));
          chk("res_cout", 64'(bus8.cout), 64'(full[8]));
        end
      end else begin
        chk("idle_busy", 64'(bus8.busy), 64'd0);
        chk("idle_done", 64'(bus8.done), 64'd0);
        chk("idle_sum",  64'(bus8.sum),  64'(full[7:0]));
      end
    end
    last_sum8  = full[7:0];
    last_cout8 = full[8];
    if (smode != 2) bus8.start = 1'b0;
  endtask

  task automatic add1(input logic av, input logic bv);
    logic [1:0] full;
    full = {1'b0, av} + {1'b0, bv};
    bus1.start = 1'b1;
    bus1.a     = av;
    bus1.b     = bv;
    step();
    bus1.start = 1'b0;
    chk("w1_acc_busy", 64'(bus1.busy), 64'd1);
    chk("w1_acc_done", 64'(bus1.done), 64'd0);
    step();
    chk("w1_done", 64'(bus1.done), 64'd1);
    chk("w1_sum",  64'(bus1.sum),  64'(full[0]));
    chk("w1_cout", 64'(bus1.cout), 64'(full[1]));
    step();
    chk("w1_idle_busy", 64'(bus1.busy), 64'd0);
    chk("w1_idle_done", 64'(bus1.done), 64'd0);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    last_sum8  = 8'h00;
    last_cout8 = 1'b0;
    rst        = 1'b1;
    bus8.start = 1'b0;
    bus8.a     = 8'h00;
    bus8.b     = 8'h00;
    bus1.start = 1'b0;
    bus1.a     = 1'b0;
    bus1.b     = 1'b0;
    step();
    step();
    chk("rst_busy", 64'(bus8.busy), 64'd0);
    chk("rst_done", 64'(bus8.done), 64'd0);
    chk("rst_sum",  64'(bus8.sum),  64'd0);
    chk("rst_cout", 64'(bus8.cout), 64'd0);
    chk("rst_w1_sum", 64'(bus1.sum), 64'd0);

    // rst and start together: rst wins, nothing is accepted
    bus8.start = 1'b1;
    step();
    rst        = 1'b0;
    bus8.start = 1'b0;
    step();
    chk("rst_start_busy", 64'(bus8.busy), 64'd0);
    step();

    // directed sums
    add8(8'h5A, 8'h3C, 0, 1'b0);
    add8(8'hFF, 8'h01, 0, 1'b0);
    add8(8'hFF, 8'hFF, 0, 1'b0);
    add8(8'h00, 8'h00, 0, 1'b0);

    // start held high: back-to-back ops, operands scrambled mid-flight
    add8(8'h10, 8'h20, 2, 1'b1);
    add8(8'h10, 8'h20, 2, 1'b1);
    add8(8'h10, 8'h20, 0, 1'b1);

    // start pulses while busy are ignored; no second done
    add8(8'h12, 8'h34, 3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_extra_done", 64'(bus8.done), 64'd0);
      chk("no_extra_busy", 64'(bus8.busy), 64'd0);
    end

    // reset mid-RUN aborts the operation
    bus8.start = 1'b1;
    bus8.a     = 8'hAA;
    bus8.b     = 8'h55;
    step();
    bus8.start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    chk("abort_busy", 64'(bus8.busy), 64'd0);
    chk("abort_done", 64'(bus8.done), 64'd0);
    chk("abort_sum",  64'(bus8.sum),  64'd0);
    chk("abort_cout", 64'(bus8.cout), 64'd0);
    rst        = 1'b0;
    last_sum8  = 8'h00;
    last_cout8 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("abort_no_done", 64'(bus8.done), 64'd0);
    end
    add8(8'h01, 8'h02, 0, 1'b0);

    // randomized operations
    for (int i = 0; i < 24; i++) begin
      add8(8'($urandom), 8'($urandom), int'($urandom_range(0, 1)), 1'b1);
    end

    // WIDTH=1 reproduces the half-adder truth table
    add1(1'b0, 1'b0);
    add1(1'b0, 1'b1);
    add1(1'b1, 1'b0);
    add1(1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
